// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM read/write/refresh arbiter.
package sdram_arb_pkg;

  localparam int unsigned ADDR_W   = 22;
  localparam int unsigned BANK_W   = 2;
  localparam int unsigned BANK_LSB = ADDR_W - BANK_W;
  localparam int unsigned WORD_W   = BANK_LSB;
  localparam int unsigned USEDW_W  = 10;

  typedef enum logic [1:0] {
    CMD_REFRESH = 2'd0,
    CMD_WRITE   = 2'd1,
    CMD_READ    = 2'd2
  } cmd_t;

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'd0,
    S_IDLE      = 2'd1,
    S_REQ       = 2'd2,
    S_BUSY      = 2'd3
  } state_t;

  typedef struct packed {
    cmd_t              kind;
    logic [ADDR_W-1:0] addr;
  } cmd_s;

  function automatic logic [ADDR_W-1:0] make_addr(input logic [BANK_W-1:0] bank,
                                                  input logic [WORD_W-1:0] word);
    return {bank, word};
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter with pending and sticky-miss flags.
module sdram_refresh_timer #(
  parameter int unsigned REF_CYCLES = 1562
) (
  input  logic clk_ref,
  input  logic rst_n,
  input  logic en,
  input  logic ack,
  output logic ref_pend,
  output logic ref_miss
);

  localparam int unsigned CNT_W = $clog2(REF_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             tc_c;

  assign tc_c = (cnt == CNT_W'(REF_CYCLES - 1));

  // Pending is only tracked once the SDRAM is usable, so power-up time never counts as a miss
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      ref_pend <= 1'b0;
      ref_miss <= 1'b0;
    end else begin
      cnt <= tc_c ? '0 : cnt + CNT_W'(1);
      if (!en)
        ref_pend <= 1'b0;
      else if (tc_c)
        ref_pend <= 1'b1;
      else if (ack)
        ref_pend <= 1'b0;
      if (tc_c && ref_pend)
        ref_miss <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Arbitrates SDRAM bursts between refresh, VGA read and camera write; tracks frame addresses.
// Define SDRAM_BANK_SWITCH_EN for double-buffered frames in banks 0/1.
module sdram_rw_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned REF_CYCLES  = 1562,
  parameter int unsigned RD_LOW_WM   = 256
) (
  input  logic               clk_ref,
  input  logic               rst_n,
  input  logic               sdram_init_done,
  input  logic               frame_valid,
  input  logic               rd_frame_start,
  input  logic [USEDW_W-1:0] wr_fifo_usedw,
  input  logic [USEDW_W-1:0] rd_fifo_usedw,
  output logic               cmd_req,
  output logic [1:0]         cmd_type,
  output logic [ADDR_W-1:0]  cmd_addr,
  input  logic               cmd_ack,
  input  logic               cmd_done,
  output logic               ref_miss
);

  localparam int unsigned SUM_W = WORD_W + 1;
  localparam logic [SUM_W-1:0] BURST_STEP = SUM_W'(BURST_LEN);
  localparam logic [SUM_W-1:0] FRAME_END  = SUM_W'(FRAME_WORDS);

  state_t             state, state_nxt;
  cmd_s               cmd_q, cmd_nxt;
  logic               req_nxt;
  logic [2:0]         fv_sync;
  logic               fv_rise_c, wr_restart, rd_restart, apply_wr_c, apply_rd_c;
  logic [WORD_W-1:0]  wr_addr, rd_addr, wr_word_c, rd_word_c, wr_next_c, rd_next_c;
  logic [SUM_W-1:0]   wr_sum_c, rd_sum_c;
  logic [BANK_W-1:0]  wr_bank_c, rd_bank_c;
  logic               ref_pend, ref_ack_c, timer_en_c;
  logic               wr_want_c, rd_want_c, done_wr_c, done_rd_c;

  assign cmd_type = cmd_q.kind;
  assign cmd_addr = cmd_q.addr;

  sdram_refresh_timer #(.REF_CYCLES(REF_CYCLES)) u_refresh_timer (
    .clk_ref  (clk_ref),
    .rst_n    (rst_n),
    .en       (timer_en_c),
    .ack      (ref_ack_c),
    .ref_pend (ref_pend),
    .ref_miss (ref_miss)
  );

  assign timer_en_c = (state != S_WAIT_INIT);
  assign ref_ack_c  = (state == S_REQ) && cmd_ack && (cmd_q.kind == CMD_REFRESH);
  assign wr_want_c  = 32'(wr_fifo_usedw) >= BURST_LEN;
  assign rd_want_c  = 32'(rd_fifo_usedw) < RD_LOW_WM;
  assign done_wr_c  = (state == S_BUSY) && cmd_done && (cmd_q.kind == CMD_WRITE);
  assign done_rd_c  = (state == S_BUSY) && cmd_done && (cmd_q.kind == CMD_READ);

  // Frame restarts are held until idle so a burst in flight finishes at its old address
  assign fv_rise_c  = fv_sync[1] & ~fv_sync[2];
  assign apply_wr_c = (state == S_IDLE) && (wr_restart || fv_rise_c);
  assign apply_rd_c = (state == S_IDLE) && (rd_restart || rd_frame_start);
  assign wr_word_c  = apply_wr_c ? '0 : wr_addr;
  assign rd_word_c  = apply_rd_c ? '0 : rd_addr;

  assign wr_sum_c  = {1'b0, wr_addr} + BURST_STEP;
  assign rd_sum_c  = {1'b0, rd_addr} + BURST_STEP;
  assign wr_next_c = (wr_sum_c >= FRAME_END) ? '0 : wr_sum_c[WORD_W-1:0];
  assign rd_next_c = (rd_sum_c >= FRAME_END) ? '0 : rd_sum_c[WORD_W-1:0];

`ifdef SDRAM_BANK_SWITCH_EN
  logic wr_bank, rd_bank, wr_bank_eff_c;

  assign wr_bank_eff_c = apply_wr_c ? ~wr_bank : wr_bank;
  assign wr_bank_c     = {1'b0, wr_bank_eff_c};
  assign rd_bank_c     = {1'b0, apply_rd_c ? ~wr_bank_eff_c : rd_bank};

  // Reader follows the bank the writer most recently finished
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (apply_wr_c) wr_bank <= ~wr_bank;
      if (apply_rd_c) rd_bank <= ~wr_bank_eff_c;
    end
  end
`else
  assign wr_bank_c = '0;
  assign rd_bank_c = '0;
`endif

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      fv_sync    <= '0;
      wr_restart <= 1'b0;
      rd_restart <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
    end else begin
      fv_sync    <= {fv_sync[1:0], frame_valid};
      wr_restart <= (wr_restart || fv_rise_c) && (state != S_IDLE);
      rd_restart <= (rd_restart || rd_frame_start) && (state != S_IDLE);
      if (apply_wr_c)     wr_addr <= '0;
      else if (done_wr_c) wr_addr <= wr_next_c;
      if (apply_rd_c)     rd_addr <= '0;
      else if (done_rd_c) rd_addr <= rd_next_c;
    end
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_WAIT_INIT;
      cmd_req <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state   <= state_nxt;
      cmd_req <= req_nxt;
      cmd_q   <= cmd_nxt;
    end
  end

  // Fixed priority refresh > read > write, decided in one idle cycle
  always_comb begin
    state_nxt = state;
    req_nxt   = cmd_req;
    cmd_nxt   = cmd_q;
    unique case (state)
      S_WAIT_INIT: begin
        if (sdram_init_done) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (!sdram_init_done) begin
          state_nxt = S_WAIT_INIT;
        end else if (ref_pend) begin
          state_nxt    = S_REQ;
          req_nxt      = 1'b1;
          cmd_nxt.kind = CMD_REFRESH;
          cmd_nxt.addr = '0;
        end else if (rd_want_c) begin
          state_nxt    = S_REQ;
          req_nxt      = 1'b1;
          cmd_nxt.kind = CMD_READ;
          cmd_nxt.addr = make_addr(rd_bank_c, rd_word_c);
        end else if (wr_want_c) begin
          state_nxt    = S_REQ;
          req_nxt      = 1'b1;
          cmd_nxt.kind = CMD_WRITE;
          cmd_nxt.addr = make_addr(wr_bank_c, wr_word_c);
        end
      end
      S_REQ: begin
        if (cmd_ack) begin
          state_nxt = S_BUSY;
          req_nxt   = 1'b0;
        end
      end
      S_BUSY: begin
        if (cmd_done) state_nxt = sdram_init_done ? S_IDLE : S_WAIT_INIT;
      end
      default: state_nxt = S_WAIT_INIT;
    endcase
  end

endmodule
